fir_filter: RTL and testbench
=============================

Name: fir_filter

Overview:
- Parameterised direct-form transposed-free (direct-form I) FIR filter on a valid-qualified sample stream.
- Signed fixed-point input and coefficients; coefficients held in a compile-time parameter table.
- Sits in the DSP datapath between a sample source and downstream consumers.
- One registered output sample is produced per accepted input sample.

Parameters:
- TAPS, 8, number of filter taps (≥2).
- IN_WIDTH, 16, signed input/output sample width.
- COEFF_WIDTH, 16, signed coefficient width.
- FRAC, 8, fractional bits of coefficients (Q-format; 1.0 = 2^FRAC).
- COEFFS, {8,16,32,72,72,32,16,8}, packed TAPS*COEFF_WIDTH vector; tap k at bits [k*COEFF_WIDTH +: COEFF_WIDTH].
  - Default is a symmetric low-pass with DC gain 256/256 = 1.0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_sample  in  IN_WIDTH  signed input sample.
- in_valid  in  1  input sample valid; sample accepted on any clk edge with in_valid=1.
- out_sample  out  IN_WIDTH  signed filtered output.
- out_valid  out  1  out_sample valid strobe, one cycle per accepted input.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-stream):
  - Immediately clears delay line x[0..TAPS-1] to 0.
  - Immediately clears out_sample to 0 and out_valid to 0.
- Delay line:
  - On a clk edge with in_valid=1: x[0] <= in_sample and x[k] <= x[k-1] for k=1..TAPS-1.
  - On a clk edge with in_valid=0: delay line holds.
- Output sum: acc = Σ COEFFS[k]*x_new[k], where x_new is the delay line including the sample being accepted. Computed combinationally from in_sample and x[0..TAPS-2].
- Accumulator width: IN_WIDTH+COEFF_WIDTH+clog2(TAPS), signed, full precision, no internal overflow.
- Scaling: result = acc >>> FRAC (arithmetic shift), rounding per Optional Feature.
- Saturation: result is clamped to [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1] before output.
- Register update on the same edge that accepts the sample:
  - out_sample <= saturated result.
  - out_valid <= 1.
- Latency: 1 clock from the accepting edge to out_valid/out_sample visible.
- On an edge with in_valid=0: out_valid <= 0; out_sample holds its last value.
- Back-to-back valids give continuous out_valid; there is no backpressure.

Optional Feature:
- Macro FIR_ROUND_EN.
  - Defined: add 2^(FRAC-1) to acc before the shift (round half up).
  - Undefined: plain arithmetic-shift truncation (round toward −∞).
- Default test values are identical in both modes (exact multiples); the rounding test below distinguishes them.

Decomposition:
- Package fir_pkg:
  - function acc_width(IN_WIDTH, COEFF_WIDTH, TAPS).
  - Default COEFFS constant.
  - Saturation min/max helper functions.
- Sub-module fir_sat: generic signed width-reducing saturator (ACC_W in, IN_WIDTH out).
- Tap multipliers are written as a generate loop inside fir_filter.

Test Plan:
- Reset: hold rst=1 two cycles with random inputs → out_sample=0, out_valid=0. Assert rst mid-stream → outputs and delay line are 0 immediately; the next valid 256 gives 8.
- Impulse: after reset, one valid 256 → single out_valid pulse with out_sample=8, then out_valid=0 while in_valid=0. Feeding valid zeros instead yields 8,16,32,72,72,32,16,8,0.
- Step following the impulse: 16 consecutive valid 256 samples → outputs 24,56,128,200,232,248,256, then 256 for the remainder. out_valid stays high 16 cycles, then drops one cycle after in_valid falls.
- Negative / idle gaps: valid -256 interleaved with in_valid=0 cycles → delay line shifts only on valid cycles; impulse response is -8,-16,-32,-72,...; out_sample holds during gaps.
- Saturation: override COEFFS all 256.
  - Step of 32767 → 32767 after one tap, and saturated at 32767 thereafter.
  - Step of -32768 → saturates at -32768.
- Rounding: valid input 1 with default COEFFS → out_sample 0 in both modes (8/256). Input 16 → 0.5 exact → out 1 with FIR_ROUND_EN, 0 without.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, default coefficient table and saturation limits for fir_filter
package fir_pkg;
  localparam int DEF_TAPS = 8;
  localparam int DEF_COEFF_W = 16;
  localparam logic [DEF_TAPS*DEF_COEFF_W-1:0] DEF_COEFFS = {
    16'd8, 16'd16, 16'd32, 16'd72, 16'd72, 16'd32, 16'd16, 16'd8
  };
  function automatic int acc_width(input int in_w, input int coeff_w, input int taps);
    return in_w + coeff_w + $clog2(taps);
  endfunction
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/fir_sat.sv
// fir_sat: clamps a wide signed value into the range of a narrower signed word
module fir_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = 35,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [OUT_W-1:0] dout
);
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_min(OUT_W));
  always_comb dout = din > HI ? HI[OUT_W-1:0] : din < LO ? LO[OUT_W-1:0] : din[OUT_W-1:0];
endmodule

// File: rtl/fir_filter.sv
// fir_filter: direct-form FIR on a valid-qualified stream with saturated, registered output.
// Define FIR_ROUND_EN for round-half-up scaling; otherwise the shift truncates toward -inf.
module fir_filter
  import fir_pkg::*;
#(
  parameter int TAPS = DEF_TAPS,
  parameter int IN_WIDTH = 16,
  parameter int COEFF_WIDTH = DEF_COEFF_W,
  parameter int FRAC = 8,
  parameter logic [TAPS*COEFF_WIDTH-1:0] COEFFS = DEF_COEFFS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [IN_WIDTH-1:0] in_sample,
  input  logic                       in_valid,
  output logic signed [IN_WIDTH-1:0] out_sample,
  output logic                       out_valid
);
  localparam int ACC_W = acc_width(IN_WIDTH, COEFF_WIDTH, TAPS);
  logic signed [IN_WIDTH-1:0] x_q [TAPS];
  logic signed [IN_WIDTH-1:0] x_d [TAPS];
  logic signed [IN_WIDTH-1:0] x_new [TAPS];
  logic signed [ACC_W-1:0] prod [TAPS];
  logic signed [ACC_W-1:0] acc, scaled;
  logic signed [IN_WIDTH-1:0] sat, out_sample_d, out_sample_q;
  logic out_valid_d, out_valid_q;
  // operands are widened before the multiply so the product keeps full precision
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    localparam logic signed [ACC_W-1:0] C = ACC_W'($signed(COEFFS[i*COEFF_WIDTH +: COEFF_WIDTH]));
    if (i == 0) begin : g_head
      assign x_new[i] = in_sample;
    end else begin : g_line
      assign x_new[i] = x_q[i-1];
    end
    assign prod[i] = C * ACC_W'(x_new[i]);
  end
`ifdef FIR_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FRAC - 1);
`endif
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + prod[k];
`ifdef FIR_ROUND_EN
    scaled = (acc + HALF) >>> FRAC;
`else
    scaled = acc >>> FRAC;
`endif
  end
  fir_sat #(.ACC_W(ACC_W), .OUT_W(IN_WIDTH)) u_sat (.din(scaled), .dout(sat));
  always_comb begin
    out_sample_d = in_valid ? sat : out_sample_q;
    out_valid_d = in_valid;
    for (int k = 0; k < TAPS; k++) x_d[k] = in_valid ? x_new[k] : x_q[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '{default: '0};
      out_sample_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      x_q <= x_d;
      out_sample_q <= out_sample_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_sample = out_sample_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: scoreboard bench for fir_filter with default and unity-per-tap coefficient builds
module tb_fir_filter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, s_valid = 1'b0;
  logic signed [15:0] in_sample = '0, s_sample = '0;
  logic signed [15:0] out_sample, s_out_sample;
  logic out_valid, s_out_valid;
  int q0[$], q1[$];
  int checks = 0, errors = 0;
  int last0 = 0, last1 = 0, e0, e1;
  localparam int RND =
`ifdef FIR_ROUND_EN
    1;
`else
    0;
`endif
  int step_exp[16] = '{24, 56, 128, 200, 232, 248, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256};
  int zero_exp[8] = '{16, 32, 72, 72, 32, 16, 8, 0};

  always #5 clk = ~clk;

  fir_filter u_dut (
    .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
    .out_sample(out_sample), .out_valid(out_valid)
  );
  fir_filter #(.COEFFS({8{16'd256}})) u_sat_dut (
    .clk(clk), .rst(rst), .in_sample(s_sample), .in_valid(s_valid),
    .out_sample(s_out_sample), .out_valid(s_out_valid)
  );

  task automatic chk(input string n, input logic signed [31:0] a, input logic signed [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid0", out_valid, 0);
      chk("rst_sample0", out_sample, 0);
      last0 = 0;
    end else if (out_valid) begin
      if (q0.size() == 0) chk("unexpected_valid0", out_valid, 0);
      else begin
        e0 = q0.pop_front();
        chk("out0", out_sample, e0);
        last0 = e0;
      end
    end else chk("hold0", out_sample, last0);
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid1", s_out_valid, 0);
      chk("rst_sample1", s_out_sample, 0);
      last1 = 0;
    end else if (s_out_valid) begin
      if (q1.size() == 0) chk("unexpected_valid1", s_out_valid, 0);
      else begin
        e1 = q1.pop_front();
        chk("out1", s_out_sample, e1);
        last1 = e1;
      end
    end else chk("hold1", s_out_sample, last1);
  end

  task automatic send(input int v, input int e);
    @(negedge clk);
    in_valid = 1'b1;
    s_valid = 1'b0;
    in_sample = 16'(v);
    q0.push_back(e);
  endtask

  task automatic ssend(input int v, input int e);
    @(negedge clk);
    s_valid = 1'b1;
    in_valid = 1'b0;
    s_sample = 16'(v);
    q1.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      s_valid = 1'b0;
      in_sample = 16'($urandom);
      s_sample = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    s_valid = 1'b0;
    #1;
    chk("async_rst_valid0", out_valid, 0);
    chk("async_rst_sample0", out_sample, 0);
    chk("async_rst_valid1", s_out_valid, 0);
    chk("async_rst_sample1", s_out_sample, 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'b1;
      s_valid = 1'b1;
      in_sample = 16'($urandom);
      s_sample = 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    s_valid = 1'b0;
    send(256, 8);
    idle(3);
    foreach (step_exp[i]) send(256, step_exp[i]);
    idle(2);
    send(256, 256);
    do_reset();
    send(256, 8);
    foreach (zero_exp[i]) send(0, zero_exp[i]);
    send(-256, -8);
    idle(2);
    send(0, -16);
    idle(1);
    send(0, -32);
    send(0, -72);
    idle(3);
    send(0, -72);
    send(0, -32);
    send(0, -16);
    send(0, -8);
    send(0, 0);
    send(1, 0);
    repeat (8) send(0, 0);
    send(16, RND);
    send(0, 1);
    idle(2);
    repeat (3) ssend(32767, 32767);
    idle(1);
    do_reset();
    repeat (3) ssend(-32768, -32768);
    idle(3);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
